// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one binary/Gray code converter among NREQ requesters.
// Define CONV_ARB_FAST_G2B_EN for single-cycle Gray->binary (CALC state and bit counter removed).
//
// state | meaning
// IDLE  | arbitrate, capture winner, start conversion
// CALC  | serial Gray->binary, one bit per cycle from MSB-1 down to bit 0
// HOLD  | result valid, waiting for out_ready
module code_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    out_mode,
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NREQ);

`ifdef CONV_ARB_FAST_G2B_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`else
  localparam int KW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;
  logic [WIDTH-1:0] g_lat;
  logic [KW-1:0]    k, k_up;
`endif

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, winner;
  logic [IDW:0]     sum;
  logic             found, grant, sel_mode;
  logic [WIDTH-1:0] sel_data, b2g;

  // Winner is the first valid requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(j);
      if (sum >= NREQ_L) sum = sum - NREQ_L;
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = req_mode[i];
      end
    end
  end

  assign grant = (state == IDLE) && found;
  assign b2g   = sel_data ^ (sel_data >> 1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = rst_n && grant && (winner == IDW'(i));
  end

`ifdef CONV_ARB_FAST_G2B_EN
  logic [WIDTH-1:0] g2b_fast;
  logic             acc;

  always_comb begin
    g2b_fast = '0;
    acc      = 1'b0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      acc         = acc ^ sel_data[i];
      g2b_fast[i] = acc;
    end
  end
`else
  assign k_up = k + KW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
`ifdef CONV_ARB_FAST_G2B_EN
        if (grant) state_nxt = HOLD;
`else
        if (grant) state_nxt = sel_mode ? CALC : HOLD;
`endif
      end
`ifndef CONV_ARB_FAST_G2B_EN
      CALC: if (k == '0) state_nxt = HOLD;
`endif
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      out_data <= '0;
      out_id   <= '0;
      out_mode <= 1'b0;
`ifndef CONV_ARB_FAST_G2B_EN
      g_lat    <= '0;
      k        <= '0;
`endif
    end else if (grant) begin
      rr_ptr   <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
      out_id   <= winner;
      out_mode <= sel_mode;
`ifdef CONV_ARB_FAST_G2B_EN
      out_data <= sel_mode ? g2b_fast : b2g;
`else
      if (sel_mode) begin
        out_data <= {sel_data[WIDTH-1], {(WIDTH-1){1'b0}}};
        g_lat    <= sel_data;
        k        <= KW'(WIDTH-2);
      end else begin
        out_data <= b2g;
      end
    end else if (state == CALC) begin
      // Each bit is the running XOR of all Gray bits above and including it.
      out_data[k] <= out_data[k_up] ^ g_lat[k];
      k           <= k - KW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Self-checking bench for code_conv_arbiter: directed steps plus randomized traffic
// checked against a behavioural arbitration/conversion model.
module tb_code_conv_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
`ifdef CONV_ARB_FAST_G2B_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_mode;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;
  int last_id;
  logic [WIDTH-1:0] last_data;

  code_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mode(req_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_mode(out_mode),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] b2g_ref(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary value is the XOR of the Gray word with all of its right shifts.
  function automatic logic [WIDTH-1:0] g2b_ref(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int model_winner();
    for (int j = 0; j < NREQ; j++)
      if (req_valid[(rr_m + j) % NREQ]) return (rr_m + j) % NREQ;
    return -1;
  endfunction

  // Called just after a negedge with inputs already driven; returns just after a negedge in IDLE.
  task automatic do_txn(input int hold);
    int w, lat;
    logic [WIDTH-1:0] d, expd;
    logic m;
    #1;
    w = model_winner();
    if (w < 0) begin
      chk("no_grant", req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      return;
    end
    chk("grant", req_ready, 32'd1 << w);
    chk("pre_busy", busy, 0);
    d    = req_data[w*WIDTH +: WIDTH];
    m    = req_mode[w];
    expd = m ? g2b_ref(d) : b2g_ref(d);
    lat  = (m && !FAST) ? WIDTH : 1;
    rr_m = (w + 1) % NREQ;
    out_ready = (hold == 0);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("ready_low", req_ready, 0);
      chk("out_valid_lat", out_valid, (c == lat));
      if (c < lat) @(posedge clk);
    end
    chk("out_data", out_data, expd);
    chk("out_id", out_id, w);
    chk("out_mode", out_mode, m);
    last_id   = int'(out_id);
    last_data = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, expd);
      chk("hold_id", out_id, w);
      chk("hold_mode", out_mode, m);
      chk("hold_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_mode  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    rr_m  = 0;

    // Binary->Gray on requester 0
    req_valid = 4'b0001;
    req_data[0*WIDTH +: WIDTH] = 4'b1011;
    req_mode = 4'b0000;
    do_txn(0);
    chk("b2g_const", last_data, 4'b1110);
    chk("b2g_id", last_id, 0);

    // Gray->binary on requester 2
    req_valid = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 4'b1110;
    req_mode = 4'b0100;
    do_txn(0);
    chk("g2b_const", last_data, 4'b1011);
    chk("g2b_id", last_id, 2);

    // Gray->binary on requester 3, all-ones result
    req_valid = 4'b1000;
    req_data[3*WIDTH +: WIDTH] = 4'b1000;
    req_mode = 4'b1000;
    do_txn(0);
    chk("g2b_r3_const", last_data, 4'b1111);
    chk("g2b_r3_id", last_id, 3);

    // Backpressure with other requesters pending, then the next grant
    req_valid = 4'b0110;
    req_data[1*WIDTH +: WIDTH] = 4'b0110;
    req_data[2*WIDTH +: WIDTH] = 4'b0011;
    req_mode = 4'b0100;
    do_txn(5);
    chk("bp_id", last_id, 1);
    do_txn(0);
    chk("bp_next_id", last_id, 2);

    // Reset in the middle of CALC aborts the transfer
    req_valid = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 4'b1110;
    req_mode = 4'b0100;
    #1;
    chk("abort_grant", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, FAST ? 0 : 1);
    req_valid = 4'b1010;
    req_data[1*WIDTH +: WIDTH] = 4'b0101;
    req_data[3*WIDTH +: WIDTH] = 4'b1001;
    req_mode  = 4'b1000;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_id", out_id, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_m  = 0;
    do_txn(0);
    chk("post_rst_id", last_id, 1);

    // Fairness: every requester valid continuously from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m  = 0;
    req_valid = '1;
    req_data  = 16'hA5C3;
    req_mode  = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      do_txn(0);
      chk("rr_order", last_id, j % NREQ);
    end

    // Randomized traffic with idle gaps and random backpressure
    for (int t = 0; t < 30; t++) begin
      req_valid = '0;
      do_txn(0);
      req_data  = 16'($urandom());
      req_mode  = 4'($urandom());
      req_valid = 4'($urandom());
      do_txn(int'($urandom_range(0, 3)));
    end

    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
